// File: rtl/mem_arbiter.sv
// Memory-port arbiter: serialises I-cache and D-cache block transfers onto one
// off-chip port with alternating priority, ready pulses, pipeline stall and timeout flag.
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [DATA_W-1:0] icache_rdata,
    output logic              icache_ready,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic [DATA_W-1:0] dcache_rdata,
    output logic              dcache_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              ostall,
    output logic              otimeout
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_t;

    localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] icache_rdata_q, icache_rdata_d;
    logic [DATA_W-1:0] dcache_rdata_q, dcache_rdata_d;
    logic              icache_ready_q, icache_ready_d;
    logic              dcache_ready_q, dcache_ready_d;
    logic              last_grant_i_q, last_grant_i_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              d_pend;

    assign d_pend = dcache_read | dcache_write;

    always_comb begin
        state_d        = state_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        icache_rdata_d = icache_rdata_q;
        dcache_rdata_d = dcache_rdata_q;
        icache_ready_d = 1'b0;
        dcache_ready_d = 1'b0;
        last_grant_i_d = last_grant_i_q;
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;

        case (state_q)
            IDLE: begin
                // With both pending, whichever side was not served last wins.
                if (d_pend && (!icache_req || last_grant_i_q)) begin
                    state_d        = D_BUSY;
                    mem_addr_d     = dcache_addr;
                    mem_write_d    = dcache_write;
                    mem_read_d     = ~dcache_write;
                    if (dcache_write) begin
                        mem_wdata_d = dcache_wdata;
                    end
                    last_grant_i_d = 1'b0;
                    cnt_d          = '0;
                end else if (icache_req) begin
                    state_d        = I_BUSY;
                    mem_addr_d     = icache_addr;
                    mem_read_d     = 1'b1;
                    mem_write_d    = 1'b0;
                    last_grant_i_d = 1'b1;
                    cnt_d          = '0;
                end
            end
            D_BUSY, I_BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_d >= TO_LIM) begin
                    timeout_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                    if (state_q == I_BUSY) begin
                        icache_rdata_d = mem_rdata;
                        icache_ready_d = 1'b1;
                    end else begin
                        dcache_rdata_d = mem_rdata;
                        dcache_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            icache_rdata_q <= '0;
            dcache_rdata_q <= '0;
            icache_ready_q <= 1'b0;
            dcache_ready_q <= 1'b0;
            last_grant_i_q <= 1'b1;
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            icache_rdata_q <= icache_rdata_d;
            dcache_rdata_q <= dcache_rdata_d;
            icache_ready_q <= icache_ready_d;
            dcache_ready_q <= dcache_ready_d;
            last_grant_i_q <= last_grant_i_d;
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign icache_rdata = icache_rdata_q;
    assign dcache_rdata = dcache_rdata_q;
    assign icache_ready = icache_ready_q;
    assign dcache_ready = dcache_ready_q;
    assign otimeout     = timeout_q;

    // Ready pulses release the stall in the same cycle the requester drops its request.
    assign ostall = ~rst & ((icache_req & ~icache_ready_q) | (d_pend & ~dcache_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of who owns the memory port.
module tb_mem_arbiter;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_req;
    logic [ADDR_W-1:0] icache_addr;
    logic [DATA_W-1:0] icache_rdata;
    logic              icache_ready;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_addr;
    logic [DATA_W-1:0] dcache_wdata;
    logic [DATA_W-1:0] dcache_rdata;
    logic              dcache_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              ostall;
    logic              otimeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_ready(icache_ready),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ostall(ostall), .otimeout(otimeout)
    );

    // Transaction-level model: owner/served are 0 = none, 1 = D-cache, 2 = I-cache.
    int                m_owner;
    int                m_served;
    int                m_busy;
    logic              m_prefer_d;
    logic              m_rd, m_wr, m_to;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_irdata, m_drdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0; m_served <= 0; m_busy <= 0; m_prefer_d <= 1'b1;
            m_rd <= 1'b0; m_wr <= 1'b0; m_to <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_irdata <= '0; m_drdata <= '0;
        end else if (m_served != 0) begin
            m_served <= 0;
        end else if (m_owner != 0) begin
            m_busy <= m_busy + 1;
            if (m_busy + 1 >= TIMEOUT) m_to <= 1'b1;
            if (mem_ready) begin
                if (m_owner == 2) m_irdata <= mem_rdata;
                else              m_drdata <= mem_rdata;
                m_served <= m_owner;
                m_owner  <= 0;
                m_rd <= 1'b0; m_wr <= 1'b0;
            end
        end else if ((dcache_read | dcache_write) && (!icache_req || m_prefer_d)) begin
            m_owner <= 1; m_busy <= 0; m_prefer_d <= 1'b0;
            m_addr <= dcache_addr;
            m_wr <= dcache_write; m_rd <= !dcache_write;
            if (dcache_write) m_wdata <= dcache_wdata;
        end else if (icache_req) begin
            m_owner <= 2; m_busy <= 0; m_prefer_d <= 1'b1;
            m_addr <= icache_addr; m_rd <= 1'b1; m_wr <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic exp_stall;
        exp_stall = (icache_req && m_served != 2) || ((dcache_read || dcache_write) && m_served != 1);
        chk("mem_read",     128'(mem_read),     128'(m_rd));
        chk("mem_write",    128'(mem_write),    128'(m_wr));
        chk("mem_addr",     128'(mem_addr),     128'(m_addr));
        chk("mem_wdata",    mem_wdata,          m_wdata);
        chk("icache_rdata", icache_rdata,       m_irdata);
        chk("dcache_rdata", dcache_rdata,       m_drdata);
        chk("icache_ready", 128'(icache_ready), 128'(m_served == 2));
        chk("dcache_ready", 128'(dcache_ready), 128'(m_served == 1));
        chk("otimeout",     128'(otimeout),     128'(m_to));
        chk("ostall",       128'(ostall),       128'(exp_stall));
    endtask

    // Compare against the model mid-cycle, then return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst) model_cmp();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [DATA_W-1:0] a5, wv, iv, dv;
        a5 = {16{8'hA5}};
        wv = 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0;
        iv = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
        dv = 128'hBEEF_CAFE_0000_0001_0000_0002_0000_0003;

        rst = 1'b1;
        icache_req = 1'b1; icache_addr = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_addr = '0; dcache_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 128'(ostall), 128'(0));
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_timeout", 128'(otimeout), 128'(0));
        chk("rst_rdata", dcache_rdata, 128'(0));
        icache_req = 1'b0;
        rst = 1'b0;

        // Simultaneous I and D after reset: D first, then I; D re-request waits.
        icache_req = 1'b1; icache_addr = 28'h0000111;
        dcache_read = 1'b1; dcache_addr = 28'h0000222;
        step();
        chk("t2_d_first", 128'(mem_addr), 128'(28'h0000222));
        chk("t2_d_read", 128'(mem_read), 128'(1));
        mem_ready = 1'b1; mem_rdata = dv;
        step();
        chk("t2_d_ready", 128'(dcache_ready), 128'(1));
        chk("t2_i_noready", 128'(icache_ready), 128'(0));
        mem_ready = 1'b0; dcache_read = 1'b0;
        step();
        chk("t2_idle_gap", 128'(mem_read), 128'(0));
        step();
        chk("t2_i_second", 128'(mem_addr), 128'(28'h0000111));
        dcache_read = 1'b1; dcache_addr = 28'h0000333;
        step();
        step();
        chk("t2_i_hold", 128'(mem_addr), 128'(28'h0000111));
        mem_ready = 1'b1; mem_rdata = iv;
        step();
        chk("t2_i_ready", 128'(icache_ready), 128'(1));
        chk("t2_i_rdata", icache_rdata, iv);
        mem_ready = 1'b0; icache_req = 1'b0;
        step();
        step();
        chk("t2_d_after", 128'(mem_addr), 128'(28'h0000333));
        mem_ready = 1'b1; mem_rdata = dv;
        step();
        mem_ready = 1'b0; dcache_read = 1'b0;
        step();

        // D refill alone, completion on the fifth busy cycle.
        dcache_read = 1'b1; dcache_addr = 28'h0000010;
        step();
        for (int k = 1; k <= 5; k++) begin
            chk("t1_mem_read", 128'(mem_read), 128'(1));
            chk("t1_stall", 128'(ostall), 128'(1));
            if (k == 5) begin mem_ready = 1'b1; mem_rdata = a5; end
            step();
        end
        chk("t1_read_off", 128'(mem_read), 128'(0));
        chk("t1_ready", 128'(dcache_ready), 128'(1));
        chk("t1_rdata", dcache_rdata, a5);
        chk("t1_stall_resp", 128'(ostall), 128'(0));
        mem_ready = 1'b0; dcache_read = 1'b0;
        step();
        chk("t1_pulse_end", 128'(dcache_ready), 128'(0));

        // Read+write together means writeback; write data latched at grant.
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_addr = 28'h0000044; dcache_wdata = wv;
        step();
        dcache_wdata = rnd128();
        for (int k = 0; k < 3; k++) begin
            chk("t3_write", 128'(mem_write), 128'(1));
            chk("t3_noread", 128'(mem_read), 128'(0));
            chk("t3_wdata", mem_wdata, wv);
            step();
        end
        mem_ready = 1'b1; mem_rdata = dv;
        step();
        chk("t3_ready", 128'(dcache_ready), 128'(1));
        mem_ready = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        step();

        // Memory silent for 300 cycles in I_BUSY: sticky timeout, still completes.
        icache_req = 1'b1; icache_addr = 28'h0ABCDEF;
        step();
        for (int k = 1; k <= 300; k++) begin
            if (k == 255) chk("t4_to_early", 128'(otimeout), 128'(0));
            if (k == 256) chk("t4_to_set", 128'(otimeout), 128'(1));
            if (k == 300) begin mem_ready = 1'b1; mem_rdata = iv; end
            step();
        end
        chk("t4_i_ready", 128'(icache_ready), 128'(1));
        chk("t4_to_sticky", 128'(otimeout), 128'(1));
        mem_ready = 1'b0; icache_req = 1'b0;
        step();

        // Stray mem_ready while idle changes nothing.
        mem_ready = 1'b1; mem_rdata = rnd128();
        step();
        chk("t6_i_ready", 128'(icache_ready), 128'(0));
        chk("t6_d_ready", 128'(dcache_ready), 128'(0));
        chk("t6_i_rdata", icache_rdata, iv);
        chk("t6_d_rdata", dcache_rdata, dv);
        mem_ready = 1'b0;
        step();

        // Asynchronous reset in the middle of a D read; request restarts afterwards.
        dcache_read = 1'b1; dcache_addr = 28'h0000055;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("t5_read_drop", 128'(mem_read), 128'(0));
        chk("t5_addr_zero", 128'(mem_addr), 128'(0));
        chk("t5_stall", 128'(ostall), 128'(0));
        chk("t5_to_clr", 128'(otimeout), 128'(0));
        chk("t5_rdata_clr", icache_rdata, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("t5_restart", 128'(mem_addr), 128'(28'h0000055));
        chk("t5_restart_rd", 128'(mem_read), 128'(1));
        mem_ready = 1'b1; mem_rdata = a5;
        step();
        mem_ready = 1'b0; dcache_read = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (icache_req && m_served == 2) icache_req = 1'b0;
            else if (icache_req && m_owner == 2 && $urandom_range(0, 40) == 0) icache_req = 1'b0;
            if (!icache_req && m_owner != 2 && m_served != 2 && $urandom_range(0, 2) == 0) begin
                icache_req = 1'b1; icache_addr = ADDR_W'($urandom());
            end
            if ((dcache_read || dcache_write) && m_served == 1) begin
                dcache_read = 1'b0; dcache_write = 1'b0;
            end else if ((dcache_read || dcache_write) && m_owner == 1 && $urandom_range(0, 40) == 0) begin
                dcache_read = 1'b0; dcache_write = 1'b0;
            end
            if (!dcache_read && !dcache_write && m_owner != 1 && m_served != 1 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: dcache_read = 1'b1;
                    2: dcache_write = 1'b1;
                    default: begin dcache_read = 1'b1; dcache_write = 1'b1; end
                endcase
                dcache_addr = ADDR_W'($urandom());
                dcache_wdata = rnd128();
            end
            mem_rdata = rnd128();
            if (m_owner != 0) mem_ready = ($urandom_range(0, 3) == 0);
            else              mem_ready = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
